lsu_sequencer: RTL and testbench
================================

# lsu_sequencer

Load/store sequencer that sits between the execute stage and `data_memory`, acting as the initiator on the memory's `write_enable`/`addrmode`/`selectbytes`/`address`/`write_data`/`read_data` interface. It accepts one load or store per handshake and issues memory beats. Misaligned accesses are split into byte beats; load bytes are merged and extended. A response pulse returns load data or a fault.

## Interface
- `ADDRESS_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_address`  in  ADDRESS_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  illegal funct3 or (macro off) misaligned.
- `mem_write_enable`  out  1  to `data_memory.write_enable`.
- `mem_addrmode`  out  3  to `data_memory.addrmode`.
- `mem_selectbytes`  out  2  equals `mem_address[1:0]`.
- `mem_address`  out  ADDRESS_WIDTH  beat address.
- `mem_write_data`  out  DATA_WIDTH  beat store data, right-aligned.
- `mem_read_data`  in  DATA_WIDTH  combinational read data from memory.

## Operation
- States:
  - IDLE → ACCESS on accept with a legal op.
  - IDLE → DONE on accept with an illegal op.
  - ACCESS → ACCESS while beats remain.
  - ACCESS → DONE after the last beat.
  - DONE → IDLE unconditionally.
- Accept means `req_valid & req_ready`. On accept, register `write`, `funct3`, `address`, `wdata`, and clear the beat counter.
- Legal ops:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is a fault: no memory access, DONE with `resp_fault=1`.
- Aligned access (h with `addr[0]=0`, w with `addr[1:0]=0`, all b): one beat.
  - `mem_addrmode` = funct3.
  - `mem_address` = registered address.
  - `mem_write_data` = wdata.
- Misaligned access: 2 beats for h, 4 for w. Beat k:
  - `mem_address` = addr + k, modulo 2^ADDRESS_WIDTH (wraps 0xFFFFFFFF → 0x0).
  - `mem_addrmode` = 000 for stores, 100 for loads.
  - `mem_write_data` = `wdata[8k+7:8k]`, zero-extended.
- Load merge:
  - Aligned: capture `mem_read_data` whole.
  - Misaligned: capture `mem_read_data[7:0]` into byte k (little-endian).
  - In DONE, extend by funct3: 001 sign from bit 15, 101 zero, 010 none.
- `mem_write_enable` is high during every ACCESS cycle of a store, gated by `rst_n`. A beat coinciding with `rst_n=0` does not write.
- `mem_*` outputs are driven only from registered state. There is no combinational path from `req_*`.

## Timing
- Accept at edge N. ACCESS occupies cycles N+1 … N+B (B = beat count). `resp_valid` is high in cycle N+B+1. `req_ready` returns in N+B+2.
- Fault latency: `resp_valid` is high in cycle N+1.
- `req_*` inputs are ignored outside IDLE.
- Reset values (any state, mid-beat included): state IDLE, `req_ready`=1, all `resp_*`=0, all `mem_*`=0.
- Idle `mem_*` outputs are 0.

## Configuration
- `LSU_MISALIGN_SPLIT_EN`:
  - Defined: misaligned accesses are split as above.
  - Undefined: misaligned h/w produce a fault with no beats (latency as illegal op), and the byte-merge datapath is omitted.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state enum;
  - a function `beat_count(funct3, addr_lo)`.
- One sub-module, `lsu_load_merge`: byte assembly register plus the extend mux.

## Test plan
- **Aligned lw:** lw 0x100, memory word 0x8899AABB → one beat, addrmode 010, selectbytes 00; `resp_valid` at N+2 with rdata 0x8899AABB.
- **Misaligned lh:** lh 0x103, mem[0x103]=0x80, mem[0x104]=0xF0 → beats 0x103, 0x104 with addrmode 100; rdata 0xFFFFF080. Same op as lhu → 0x0000F080.
- **Misaligned sw:** sw 0x201, data 0x11223344 → 4 write beats at 0x201–0x204 with data 0x44, 0x33, 0x22, 0x11; resp at N+5, fault 0.
- **Illegal funct3:** load funct3 011 → no `mem_write_enable`, `resp_valid` at N+1 with fault 1, rdata 0.
- **Reset mid-op:** `rst_n` low during beat 3 of the above sw → no write in that cycle or after; `req_ready`=1 after release. Also lh at 0xFFFFFFFF → beats 0xFFFFFFFF, 0x00000000.
- **Macro off:** lw 0x102 → fault 1, zero memory beats.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencer.
//   - funct3 encodings for the supported load/store widths
//   - sequencer state enum
//   - beat_count(): number of memory beats for an access
//   - op_legal(): funct3 legality for loads and stores
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // One beat when naturally aligned; otherwise one byte beat per byte.
  function automatic logic [2:0] beat_count(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic [2:0] n;
    n = 3'd1;
    if ((funct3[1:0] == 2'b01) && addr_lo[0])
      n = 3'd2;
    else if ((funct3 == F3_W) && (addr_lo != 2'b00))
      n = 3'd4;
    return n;
  endfunction

  function automatic logic op_legal(input logic       write,
                                    input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (!write)
      ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_merge.sv
// lsu_load_merge: load data assembly register plus sign/zero extension.
//   clk, rst_n       clock, synchronous active-low reset
//   capture_word     store mem_read_data whole (aligned load beat)
//   capture_byte     store mem_read_data[7:0] into byte byte_idx (split beat)
//   byte_idx         little-endian byte lane for capture_byte
//   mem_read_data    read data from memory
//   funct3           load width/signedness used for extension
//   load_data        extended load result
// Macro LSU_MISALIGN_SPLIT_EN: when undefined the byte-lane path is omitted.
module lsu_load_merge
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture_word,
  input  logic                  capture_byte,
  input  logic [1:0]            byte_idx,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (capture_word)
      data_d = mem_read_data;
`ifdef LSU_MISALIGN_SPLIT_EN
    else if (capture_byte)
      data_d[{byte_idx, 3'b000} +: 8] = mem_read_data[7:0];
`endif
  end

`ifndef LSU_MISALIGN_SPLIT_EN
  logic unused_byte_path;
  assign unused_byte_path = capture_byte ^ (^byte_idx);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){data_q[7]}}, data_q[7:0]};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, data_q[7:0]};
      F3_H:    load_data = {{(DATA_WIDTH-16){data_q[15]}}, data_q[15:0]};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, data_q[15:0]};
      default: load_data = data_q;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: accepts one load/store per handshake and issues memory beats
// to data_memory; returns a one-cycle response with load data or a fault.
//   req_*   request handshake (req_ready high only in IDLE)
//   resp_*  one-cycle response pulse, extended load data, fault flag
//   mem_*   memory initiator interface, driven from registered state only
// Macro LSU_MISALIGN_SPLIT_EN: defined -> misaligned h/w split into byte
// beats; undefined -> misaligned h/w fault without any memory beat.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_fault,
  output logic                     mem_write_enable,
  output logic [2:0]               mem_addrmode,
  output logic [1:0]               mem_selectbytes,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [1:0]               beat_q, beat_d;
  logic                     fault_q, fault_d;

  logic [2:0]               nbeats;
  logic                     split;
  logic                     req_ok;
  logic                     load_beat;
  logic [DATA_WIDTH-1:0]    load_data;

  assign nbeats    = beat_count(funct3_q, addr_q[1:0]);
  assign split     = (nbeats != 3'd1);
  assign load_beat = (state_q == ACCESS) && !write_q;

  always_comb begin
    req_ok = op_legal(req_write, req_funct3);
`ifndef LSU_MISALIGN_SPLIT_EN
    if (beat_count(req_funct3, req_address[1:0]) != 3'd1)
      req_ok = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_address;
          wdata_d  = req_wdata;
          beat_d   = '0;
          fault_d  = !req_ok;
          state_d  = req_ok ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if ({1'b0, beat_q} == (nbeats - 3'd1))
          state_d = DONE;
        else
          beat_d = beat_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beat_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      fault_q  <= fault_d;
    end
  end

  // Outputs are qualified by rst_n so that a beat overlapping reset never
  // writes and every output shows its reset value during reset.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_fault       = 1'b0;
    resp_rdata       = '0;
    mem_write_enable = 1'b0;
    mem_addrmode     = '0;
    mem_address      = '0;
    mem_write_data   = '0;
    if (!rst_n) begin
      req_ready = 1'b1;
    end else begin
      case (state_q)
        IDLE: req_ready = 1'b1;
        ACCESS: begin
          mem_write_enable = write_q;
          mem_address      = addr_q + ADDRESS_WIDTH'(beat_q);
          if (split) begin
            mem_addrmode   = write_q ? F3_B : F3_BU;
            mem_write_data = DATA_WIDTH'(wdata_q[{beat_q, 3'b000} +: 8]);
          end else begin
            mem_addrmode   = funct3_q;
            mem_write_data = wdata_q;
          end
        end
        DONE: begin
          resp_valid = 1'b1;
          resp_fault = fault_q;
          if (!write_q && !fault_q)
            resp_rdata = load_data;
        end
        default: ;
      endcase
    end
  end

  assign mem_selectbytes = mem_address[1:0];

  lsu_load_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_merge (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_word (load_beat && !split),
    .capture_byte (load_beat && split),
    .byte_idx     (beat_q),
    .mem_read_data(mem_read_data),
    .funct3       (funct3_q),
    .load_data    (load_data)
  );

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: drives directed and random loads/stores into
// lsu_sequencer, emulates data_memory on its mem_* port, and compares every
// beat and response against a byte-level reference model of the access rules.
// Honors LSU_MISALIGN_SPLIT_EN the same way the design does.
module tb_lsu_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_fault;
  logic          mem_write_enable;
  logic [2:0]    mem_addrmode;
  logic [1:0]    mem_selectbytes;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_sequencer #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_address     (req_address),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .mem_write_enable(mem_write_enable),
    .mem_addrmode    (mem_addrmode),
    .mem_selectbytes (mem_selectbytes),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  // data_memory emulation: 256 bytes indexed by address[7:0].
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       poke_en = 1'b0;
  logic [7:0] poke_idx = '0;
  logic [7:0] poke_val = '0;
  logic [7:0] rb0, rb1, rb2, rb3;

  always_comb begin
    rb0 = mem[mem_address[7:0]];
    rb1 = mem[mem_address[7:0] + 8'd1];
    rb2 = mem[mem_address[7:0] + 8'd2];
    rb3 = mem[mem_address[7:0] + 8'd3];
    case (mem_addrmode)
      3'b000:  mem_read_data = {{24{rb0[7]}}, rb0};
      3'b100:  mem_read_data = {24'h0, rb0};
      3'b001:  mem_read_data = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  mem_read_data = {16'h0, rb1, rb0};
      default: mem_read_data = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_idx] <= poke_val;
    if (mem_write_enable) begin
      mem[mem_address[7:0]] <= mem_write_data[7:0];
      if (mem_addrmode != 3'b000)
        mem[mem_address[7:0] + 8'd1] <= mem_write_data[15:8];
      if (mem_addrmode == 3'b010) begin
        mem[mem_address[7:0] + 8'd2] <= mem_write_data[23:16];
        mem[mem_address[7:0] + 8'd3] <= mem_write_data[31:24];
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [7:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  function automatic int unsigned op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    32'(mem_write_enable), 32'd0);
    check({tag, "_addr"},  mem_address, 32'd0);
    check({tag, "_mode"},  32'(mem_addrmode), 32'd0);
    check({tag, "_wdata"}, mem_write_data, 32'd0);
    check({tag, "_rv"},    32'(resp_valid), 32'd0);
    check({tag, "_rd"},    resp_rdata, 32'd0);
    check({tag, "_rf"},    32'(resp_fault), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // One full transaction; rst_beat > 0 pulls reset low during that beat.
  task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int unsigned rst_beat);
    bit          legal, mis, fault;
    int unsigned nb, sz;
    logic [31:0] raw, exp_rd, ba;
    legal = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    fault = !legal;
`else
    fault = !legal || mis;
`endif
    sz = op_size(f3);
    nb = fault ? 0 : (mis ? sz : 1);
    raw = '0;
    for (int unsigned k = 0; k < sz; k++) begin
      ba = a + 32'(k);
      raw[8*k +: 8] = ref_mem[ba[7:0]];
    end
    case (f3)
      3'b000:  exp_rd = {{24{raw[7]}}, raw[7:0]};
      3'b100:  exp_rd = {24'h0, raw[7:0]};
      3'b001:  exp_rd = {{16{raw[15]}}, raw[15:0]};
      3'b101:  exp_rd = {16'h0, raw[15:0]};
      default: exp_rd = raw;
    endcase
    if (wr || fault) exp_rd = '0;

    @(negedge clk);
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_funct3  = f3;
    req_address = a;
    req_wdata   = wd;
    @(posedge clk);
    #1;
    // Junk on req_* while busy must be ignored.
    req_write   = 1'($urandom);
    req_funct3  = 3'($urandom);
    req_address = $urandom;
    req_wdata   = $urandom;

    for (int unsigned c = 1; c <= nb + 1; c++) begin
      @(negedge clk);
      if (c <= nb) begin
        ba = a + 32'(c - 1);
        check("beat_addr", mem_address, ba);
        check("beat_sel", 32'(mem_selectbytes), 32'(ba[1:0]));
        check("beat_mode", 32'(mem_addrmode), mis ? (wr ? 32'd0 : 32'd4) : 32'(f3));
        check("beat_we", 32'(mem_write_enable), 32'(wr));
        check("beat_wdata", mem_write_data, mis ? 32'(wd[8*(c-1) +: 8]) : wd);
        check("beat_rv", 32'(resp_valid), 32'd0);
        check("beat_ready", 32'(req_ready), 32'd0);
        if (rst_beat == c) begin
          rst_n = 1'b0;
          #1;
          check_idle_outputs("rst_mid");
          @(posedge clk);
          @(negedge clk);
          check_idle_outputs("rst_held");
          rst_n     = 1'b1;
          req_valid = 1'b0;
          @(negedge clk);
          check_idle_outputs("rst_after");
          return;
        end
        if (wr) begin
          if (mis) ref_mem[ba[7:0]] = wd[8*(c-1) +: 8];
          else begin
            for (int unsigned k = 0; k < sz; k++) begin
              ba = a + 32'(k);
              ref_mem[ba[7:0]] = wd[8*k +: 8];
            end
          end
        end
      end else begin
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_fault", 32'(resp_fault), 32'(fault));
        check("resp_rdata", resp_rdata, exp_rd);
        check("done_we", 32'(mem_write_enable), 32'd0);
        check("done_addr", mem_address, 32'd0);
        check("done_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle_outputs("post");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    // Aligned lw
    poke(8'h00, 8'hBB); poke(8'h01, 8'hAA); poke(8'h02, 8'h99); poke(8'h03, 8'h88);
    do_op(1'b0, 3'b010, 32'h0000_0100, $urandom, 0);
    // Misaligned lh / lhu
    poke(8'h03, 8'h80); poke(8'h04, 8'hF0);
    do_op(1'b0, 3'b001, 32'h0000_0103, $urandom, 0);
    do_op(1'b0, 3'b101, 32'h0000_0103, $urandom, 0);
    // Misaligned sw, then readback
    do_op(1'b1, 3'b010, 32'h0000_0201, 32'h1122_3344, 0);
    do_op(1'b0, 3'b010, 32'h0000_0201, $urandom, 0);
    do_op(1'b0, 3'b010, 32'h0000_0200, $urandom, 0);
    // Illegal funct3 for load and store
    do_op(1'b0, 3'b011, 32'h0000_0100, $urandom, 0);
    do_op(1'b1, 3'b100, 32'h0000_0100, $urandom, 0);
    do_op(1'b1, 3'b111, 32'h0000_0104, $urandom, 0);
    // Reset during a store beat, then readback
`ifdef LSU_MISALIGN_SPLIT_EN
    do_op(1'b1, 3'b010, 32'h0000_0201, 32'hA5B6_C7D8, 3);
`else
    do_op(1'b1, 3'b010, 32'h0000_0204, 32'hA5B6_C7D8, 1);
`endif
    do_op(1'b0, 3'b010, 32'h0000_0200, $urandom, 0);
    do_op(1'b0, 3'b010, 32'h0000_0204, $urandom, 0);
    // Address wrap
    poke(8'hFF, 8'h34); poke(8'h00, 8'h92);
    do_op(1'b0, 3'b001, 32'hFFFF_FFFF, $urandom, 0);
    do_op(1'b1, 3'b010, 32'hFFFF_FFFE, $urandom, 0);
    do_op(1'b0, 3'b010, 32'hFFFF_FFFE, $urandom, 0);
    // Misaligned lw
    do_op(1'b0, 3'b010, 32'h0000_0102, $urandom, 0);

    for (int unsigned i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = {($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'h000001, 8'($urandom)};
      do_op(1'($urandom), 3'($urandom), ra, $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
